// File: rtl/apb_regfile_completer_pkg.sv
// Shared types and constants for the APB register-file completer.
// Holds the FSM state encoding, register map indices and field positions.
// Pure declarations plus one saturating-increment helper; no logic of its own.
package apb_regfile_completer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    localparam int CTRL_IDX   = 0;
    localparam int STATUS_IDX = 1;

    // CTRL.WAIT field position
    localparam int WAIT_LSB = 0;
    localparam int WAIT_MSB = 3;
    localparam int WAIT_W   = WAIT_MSB - WAIT_LSB + 1;

    // STATUS counter width (OK count in the low half, error count in the high half)
    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/apb_regfile_completer_if.sv
// APB bus bundle between the fabric (master) and the register-file completer (slave).
// No storage; signals pass straight through.
// Flow control is APB PREADY driven by the slave side.
interface apb_regfile_completer_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
);
    logic                 PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [ADDR_W-1:0]    PADDR;
    logic [WIDTH-1:0]     PWDATA;
    logic [WIDTH/8-1:0]   PSTRB;
    logic                 PREADY;
    logic [WIDTH-1:0]     PRDATA;
    logic                 PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_cmp_regbank.sv
// Register storage: CTRL + scratch words with byte-strobe writes, STATUS OK/error counters.
// Read is combinational from the current register state; writes land on the next clock edge.
// No backpressure; the caller decides when wr_en / counter increments fire.
module apb_cmp_regbank
    import apb_regfile_completer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [WIDTH-1:0]     rd_dat,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [WIDTH-1:0]     wr_dat,
    input  logic [WIDTH/8-1:0]   wr_strb,
    input  logic                 ok_inc,
    input  logic                 err_inc,
    output logic [WAIT_W-1:0]    wait_val
);
    localparam logic [IDX_W-1:0] STATUS_I = IDX_W'(STATUS_IDX);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Next register state: byte-lane merge of write data, saturating counters
    always_comb begin
        regs_d    = regs_q;
        ok_cnt_d  = ok_inc  ? sat_inc(ok_cnt_q)  : ok_cnt_q;
        err_cnt_d = err_inc ? sat_inc(err_cnt_q) : err_cnt_q;
        // STATUS is counter-backed, so its storage slot is never written
        if (wr_en && (wr_idx != STATUS_I)) begin
            for (int b = 0; b < WIDTH/8; b++) begin
                if (wr_strb[b]) begin
                    regs_d[wr_idx][b*8 +: 8] = wr_dat[b*8 +: 8];
                end
            end
        end
    end

    // Register state, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q    <= '{default: '0};
            ok_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            regs_q    <= regs_d;
            ok_cnt_q  <= ok_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Read mux: STATUS is assembled from the counters, everything else from storage
    always_comb begin
        rd_dat = '0;
        if (rd_idx == STATUS_I) begin
            rd_dat = WIDTH'({err_cnt_q, ok_cnt_q});
        end else if (int'(rd_idx) < DEPTH) begin
            rd_dat = regs_q[rd_idx];
        end
    end

    assign wait_val = regs_q[CTRL_IDX][WAIT_MSB:WAIT_LSB];

endmodule

// File: rtl/apb_regfile_completer.sv
// APB completer fronting a word-addressed register file with PSLVERR decode.
// Latency: setup + 1 + CTRL.WAIT access cycles; outputs are registered (Moore FSM).
// Inserts CTRL.WAIT wait states via PREADY; PSEL drop before completion aborts the transfer.
module apb_regfile_completer
    import apb_regfile_completer_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    apb_regfile_completer_if.slave apb
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int STRB_W = WIDTH / 8;
    localparam logic [IDX_W-1:0] STATUS_I = IDX_W'(STATUS_IDX);

    state_e              state_q,   state_d;
    logic [WAIT_W-1:0]   cnt_q,     cnt_d;
    logic [IDX_W-1:0]    idx_q,     idx_d;
    logic                write_q,   write_d;
    logic [STRB_W-1:0]   strb_q,    strb_d;
    logic                err_q,     err_d;
    logic                pready_q,  pready_d;
    logic [WIDTH-1:0]    prdata_q,  prdata_d;
    logic                pslverr_q, pslverr_d;

    logic                setup;
    logic [IDX_W-1:0]    set_idx;
    logic                set_err;
    logic [IDX_W-1:0]    rd_idx;
    logic [WIDTH-1:0]    rd_dat;
    logic [WAIT_W-1:0]   wait_val;
    logic                wr_en;
    logic                ok_inc;
    logic                err_inc;

    // Decode the address presented during the setup phase into index and error
    always_comb begin
        setup   = apb.PSEL && !apb.PENABLE;
        set_idx = apb.PADDR[2 +: IDX_W];
        set_err = 1'b0;
        if (apb.PADDR[1:0] != 2'b00)                 set_err = 1'b1;
        if (int'(set_idx) >= DEPTH)                  set_err = 1'b1;
        if (|apb.PADDR[ADDR_W-1:IDX_W+2])            set_err = 1'b1;
        if (apb.PWRITE && (set_idx == STATUS_I))     set_err = 1'b1;
    end

    // Zero-wait transfers read on the setup edge, so the read port follows the live address in IDLE
    assign rd_idx = (state_q == ST_IDLE) ? set_idx : idx_q;

    // Next-state and registered-output logic for IDLE -> (WAIT) -> READY -> IDLE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        strb_d    = strb_q;
        err_d     = err_q;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        wr_en     = 1'b0;
        ok_inc    = 1'b0;
        err_inc   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A bare PENABLE with no preceding setup is ignored here
                if (setup) begin
                    idx_d   = set_idx;
                    write_d = apb.PWRITE;
                    strb_d  = apb.PSTRB;
                    err_d   = set_err;
                    cnt_d   = wait_val;
                    if (wait_val == '0) begin
                        state_d   = ST_READY;
                        pready_d  = 1'b1;
                        pslverr_d = set_err;
                        prdata_d  = (set_err || apb.PWRITE) ? '0 : rd_dat;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (!apb.PSEL) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == WAIT_W'(1)) begin
                        state_d   = ST_READY;
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        prdata_d  = (err_q || write_q) ? '0 : rd_dat;
                    end
                end
            end

            ST_READY: begin
                state_d = ST_IDLE;
                // Only a transfer the master actually completes commits and counts
                if (apb.PSEL && apb.PENABLE) begin
                    wr_en   = write_q && apb.PWRITE && !err_q;
                    ok_inc  = !err_q;
                    err_inc = err_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, transfer context and bus outputs
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            strb_q    <= '0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            strb_q    <= strb_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign apb.PREADY  = pready_q;
    assign apb.PRDATA  = prdata_q;
    assign apb.PSLVERR = pslverr_q;

    apb_cmp_regbank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_regbank (
        .clk      (PCLK),
        .rst      (PRESET),
        .rd_idx   (rd_idx),
        .rd_dat   (rd_dat),
        .wr_en    (wr_en),
        .wr_idx   (idx_q),
        .wr_dat   (apb.PWDATA),
        .wr_strb  (strb_q),
        .ok_inc   (ok_inc),
        .err_inc  (err_inc),
        .wait_val (wait_val)
    );

endmodule
